// File: rtl/eq_tap_pkg.sv
// eq_tap_pkg: shared defaults, loader state type and EQ-setting-to-filter mapping for eq_tap_loader.
package eq_tap_pkg;
    localparam int DEF_NUM_TAPS   = 8;
    localparam int DEF_COEF_W     = 16;
    localparam int DEF_ADDR_W     = 12;
    localparam int DEF_EQ_W       = 8;
    localparam int DEF_STABLE_CYC = 64;
    localparam int FILT_W         = 4;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, PENDING} tap_ld_state_t;

    function automatic logic [FILT_W-1:0] eq_to_filter(input logic [DEF_EQ_W-1:0] eq_val);
        return eq_val[DEF_EQ_W-1 -: FILT_W];
    endfunction
endpackage

// File: rtl/eq_sel_debounce.sv
// eq_sel_debounce: filter-index select; with EQ_TAP_HYST_EN defined the index must differ
// from the current target for STABLE_CYC consecutive cycles before it is adopted.
module eq_sel_debounce import eq_tap_pkg::*; #(
    parameter int STABLE_CYC = DEF_STABLE_CYC
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [FILT_W-1:0] i_raw,
    output logic [FILT_W-1:0] o_tgt
);
`ifdef EQ_TAP_HYST_EN
    localparam int CNT_W = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;

    logic [FILT_W-1:0] r_tgt;
    logic [CNT_W-1:0]  r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tgt <= '0;
            r_cnt <= '0;
        end else if (i_raw == r_tgt) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_W'(STABLE_CYC - 1)) begin
            r_tgt <= i_raw;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tgt = r_tgt;
`else
    logic w_unused;

    assign w_unused = ^{i_clk, i_rst_n, 1'(STABLE_CYC)};
    assign o_tgt    = i_raw;
`endif
endmodule

// File: rtl/eq_tap_loader.sv
// eq_tap_loader: fetches the selected filter's taps from the coefficient ROM into a shadow bank
// and commits them to the active bank on a sample boundary. Build option: EQ_TAP_HYST_EN.
module eq_tap_loader import eq_tap_pkg::*; #(
    parameter int NUM_TAPS   = DEF_NUM_TAPS,
    parameter int COEF_W     = DEF_COEF_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int EQ_W       = DEF_EQ_W,
    parameter int STABLE_CYC = DEF_STABLE_CYC
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [EQ_W-1:0]            i_eq_val,
    input  logic                       i_sample_strobe,
    output logic [ADDR_W-1:0]          o_rom_addr,
    input  logic [COEF_W-1:0]          i_rom_data,
    output logic [NUM_TAPS*COEF_W-1:0] o_taps,
    output logic                       o_taps_valid,
    output logic [FILT_W-1:0]          o_active_filter,
    output logic                       o_busy
);
    localparam int TAP_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS - 1);

    typedef logic [0:NUM_TAPS-1][COEF_W-1:0] bank_t;

    tap_ld_state_t     r_state, w_next;
    logic [TAP_W-1:0]  r_tap, w_cap_idx;
    logic [FILT_W-1:0] r_ld_tgt, r_active, w_raw, w_tgt;
    logic [ADDR_W-1:0] r_rom_addr;
    logic              r_valid;
    bank_t             r_shadow, r_taps, w_shadow;
    logic              w_req, w_abort, w_start, w_step, w_cap, w_commit;

    assign w_raw = eq_to_filter(i_eq_val);

    eq_sel_debounce #(.STABLE_CYC(STABLE_CYC)) u_sel (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_raw   (w_raw),
        .o_tgt   (w_tgt)
    );

    assign w_req   = (w_tgt != r_active) || !r_valid;
    assign w_abort = (r_state != IDLE) && (w_tgt != r_ld_tgt);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE || w_abort)
            w_next = w_req ? FETCH : IDLE;
        else if (r_state == FETCH)
            w_next = (r_tap == LAST_TAP) ? DRAIN : FETCH;
        else if (r_state == DRAIN)
            w_next = r_valid ? PENDING : IDLE;
        else
            w_next = i_sample_strobe ? IDLE : PENDING;
    end

    // A target change masks capture and commit, so it beats a strobe on the same edge.
    always_comb begin
        w_start   = (r_state == IDLE || w_abort) && w_req;
        w_step    = (r_state == FETCH) && !w_abort && (r_tap != LAST_TAP);
        w_cap     = !w_abort && ((r_state == FETCH && r_tap != '0) || r_state == DRAIN);
        w_cap_idx = (r_state == DRAIN) ? LAST_TAP : r_tap - TAP_W'(1);
        w_commit  = !w_abort && ((r_state == DRAIN && !r_valid) || (r_state == PENDING && i_sample_strobe));
        w_shadow  = r_shadow;
        if (w_cap)
            w_shadow[w_cap_idx] = i_rom_data;
        o_busy    = r_state != IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tap      <= '0;
            r_ld_tgt   <= '0;
            r_rom_addr <= '0;
            r_shadow   <= '0;
            r_taps     <= '0;
            r_active   <= '0;
            r_valid    <= 1'b0;
        end else begin
            if (w_start) begin
                r_tap      <= '0;
                r_ld_tgt   <= w_tgt;
                r_rom_addr <= ADDR_W'(w_tgt) * ADDR_W'(NUM_TAPS);
            end else if (w_step) begin
                r_tap      <= r_tap + TAP_W'(1);
                r_rom_addr <= r_rom_addr + ADDR_W'(1);
            end
            r_shadow <= w_shadow;
            if (w_commit) begin
                r_taps   <= w_shadow;
                r_active <= r_ld_tgt;
                r_valid  <= 1'b1;
            end
        end
    end

    assign o_rom_addr      = r_rom_addr;
    assign o_taps          = r_taps;
    assign o_taps_valid    = r_valid;
    assign o_active_filter = r_active;
endmodule
